// File: rtl/riscv_pipe_stage_pkg.sv
// Shared definitions for the pipeline stage register: datapath width and
// the (main_valid, skid_valid) state encoding.
package riscv_pipe_stage_pkg;

    localparam int unsigned XLEN = 32;

    // bit 0 = main slot valid, bit 1 = skid slot valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/riscv_pipe_stage_slot.sv
// One data slot of the pipeline stage: WIDTH-bit register with load enable
// and synchronous clear to RESET_VAL (reset has priority over clear).
module riscv_pipe_slot #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/riscv_pipe_stage.sv
// Inter-stage pipeline register with 2-entry skid buffer, stall hold and flush.
// Optional stalled-cycle counter enabled by RISCV_PIPE_STAGE_PERF_EN.
module riscv_pipe_stage
    import riscv_pipe_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter int unsigned           NUM_CH     = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_clr,
    input  logic                         i_stall,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data
`ifdef RISCV_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                  o_stall_cnt
`endif
);

    localparam int unsigned W = NUM_CH * DATA_WIDTH;
    localparam logic [W-1:0] RESET_WORD = {NUM_CH{RESET_VAL}};

    pipe_state_e  state_q, state_d;
    logic         in_fire, out_fire;
    logic         load_main, load_skid, main_from_skid;
    logic [W-1:0] skid_q, main_d;

    // Both handshake flags come straight from state bits, so o_ready never
    // sees i_ready/i_stall combinationally.
    assign o_valid  = state_q[0];
    assign o_ready  = ~state_q[1];
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready & ~i_stall;
    assign main_d   = main_from_skid ? skid_q : i_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (i_clr) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_HALF;
                        load_main = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (in_fire && !out_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_HALF;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    riscv_pipe_slot #(
        .WIDTH     (W),
        .RESET_VAL (RESET_WORD)
    ) u_main (
        .clk  (i_clk),
        .rstn (i_rstn),
        .clr  (i_clr),
        .load (load_main),
        .d    (main_d),
        .q    (o_data)
    );

    riscv_pipe_slot #(
        .WIDTH     (W),
        .RESET_VAL (RESET_WORD)
    ) u_skid (
        .clk  (i_clk),
        .rstn (i_rstn),
        .clr  (i_clr),
        .load (load_skid),
        .d    (i_data),
        .q    (skid_q)
    );

`ifdef RISCV_PIPE_STAGE_PERF_EN
    // Survives flush on purpose: only reset clears the statistic.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_stall_cnt <= '0;
        end else if (o_valid && (i_stall || !i_ready) && !i_clr) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Self-checking bench for riscv_pipe_stage: three parameterisations driven in
// lock-step against a queue-based model of a 2-deep FIFO stage.
module tb_riscv_pipe_stage;

    logic         clk = 1'b0;
    logic         rstn, clr, stall, valid, ready;
    logic [127:0] din;

    logic         rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [95:0]  dat_a;
    logic [63:0]  dat_b;
    logic [127:0] dat_c;
`ifdef RISCV_PIPE_STAGE_PERF_EN
    logic [31:0]  cnt_a, cnt_b, cnt_c;
`endif

    logic [127:0] q[$];
    logic [127:0] last_out;
    logic [31:0]  cnt_m;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    riscv_pipe_stage dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_stall(stall),
        .i_valid(valid), .o_ready(rdy_a), .i_data(din[95:0]),
        .o_valid(vld_a), .i_ready(ready), .o_data(dat_a)
`ifdef RISCV_PIPE_STAGE_PERF_EN
        , .o_stall_cnt(cnt_a)
`endif
    );

    riscv_pipe_stage #(.DATA_WIDTH(64), .NUM_CH(1)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_stall(stall),
        .i_valid(valid), .o_ready(rdy_b), .i_data(din[63:0]),
        .o_valid(vld_b), .i_ready(ready), .o_data(dat_b)
`ifdef RISCV_PIPE_STAGE_PERF_EN
        , .o_stall_cnt(cnt_b)
`endif
    );

    riscv_pipe_stage #(.DATA_WIDTH(32), .NUM_CH(4)) dut_c (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_stall(stall),
        .i_valid(valid), .o_ready(rdy_c), .i_data(din),
        .o_valid(vld_c), .i_ready(ready), .o_data(dat_c)
`ifdef RISCV_PIPE_STAGE_PERF_EN
        , .o_stall_cnt(cnt_c)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] e;
        logic         ev, er;
        e  = last_out;
        ev = (q.size() > 0);
        er = (q.size() < 2);
        chk("a_valid", vld_a, ev);
        chk("a_ready", rdy_a, er);
        chk("a_data",  dat_a, e[95:0]);
        chk("b_valid", vld_b, ev);
        chk("b_ready", rdy_b, er);
        chk("b_data",  dat_b, e[63:0]);
        chk("c_valid", vld_c, ev);
        chk("c_ready", rdy_c, er);
        chk("c_data",  dat_c, e);
`ifdef RISCV_PIPE_STAGE_PERF_EN
        chk("a_stall_cnt", cnt_a, cnt_m);
        chk("b_stall_cnt", cnt_b, cnt_m);
        chk("c_stall_cnt", cnt_c, cnt_m);
`endif
    endtask

    // One clock: drive inputs, advance the model by the stage's transfer rules, check.
    task automatic step(input logic rn, input logic cl, input logic st,
                        input logic v, input logic r, input logic [127:0] d);
        logic in_ok, out_ok, perf;
        rstn = rn; clr = cl; stall = st; valid = v; ready = r; din = d;
        in_ok  = v && (q.size() < 2);
        out_ok = (q.size() > 0) && r && !st;
        perf   = (q.size() > 0) && (st || !r) && !cl;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            last_out = '0;
            cnt_m    = '0;
        end else begin
            cnt_m = cnt_m + 32'(perf);
            if (cl) begin
                q.delete();
                last_out = '0;
            end else begin
                if (out_ok) void'(q.pop_front());
                if (in_ok) q.push_back(d);
                if (q.size() > 0) last_out = q[0];
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        last_out = '0;
        cnt_m    = '0;

        // Reset for two cycles
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 1, 128'hdead);

        // Streaming 1..8 at full rate, then drain
        for (int k = 1; k <= 8; k++) step(1, 0, 0, 1, 1, 128'(k));
        step(1, 0, 0, 0, 1, '0);

        // Backpressure: A, B fill both slots, C refused; then drain in order
        step(1, 0, 0, 1, 0, 128'hA);
        step(1, 0, 0, 1, 0, 128'hB);
        step(1, 0, 0, 1, 0, 128'hC);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, '0);

        // Stall holds word X for three cycles despite i_ready
        step(1, 0, 0, 1, 1, 128'h5A5A);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1, '0);
        step(1, 0, 0, 0, 1, '0);

        // Flush from FULL with a coincident incoming word
        step(1, 0, 0, 1, 0, 128'h11);
        step(1, 0, 0, 1, 0, 128'h22);
        step(1, 1, 1, 1, 1, 128'h33);
        step(1, 0, 0, 0, 1, '0);

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 200) != 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 {$urandom, $urandom, $urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
